// File: rtl/cheri_tag_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cheri_tag_arbiter_pkg
//
// Shared CHERI tag-path definitions used by the tag arbiter and its order FIFO.
//   XLEN               : integer register width of the core (64).
//   CAP_GRANULE_BYTES  : bytes covered by one capability tag bit (2*XLEN/8).
//   PORT_IDX_W         : width of a requester index, sized for the largest
//                        supported requester count (8).
//   arb_state_e        : arbiter FSM states.
//   tag_order_t        : one response-order FIFO entry {port, we}.
//   granule_idx()      : byte address -> capability granule index.
// -----------------------------------------------------------------------------
package cheri_tag_arbiter_pkg;

  localparam int unsigned XLEN              = 64;
  localparam int unsigned CAP_GRANULE_BYTES = 2 * XLEN / 8;
  localparam int unsigned MAX_PORTS         = 8;
  localparam int unsigned PORT_IDX_W        = $clog2(MAX_PORTS);

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // The port field is sized for the widest legal requester count so that a
  // single package serves every arbiter configuration.
  typedef struct packed {
    logic [PORT_IDX_W-1:0] port;
    logic                  we;
  } tag_order_t;

  function automatic logic [XLEN-1:0] granule_idx(input logic [XLEN-1:0] addr,
                                                  input int unsigned     shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/tag_order_fifo.sv
// -----------------------------------------------------------------------------
// tag_order_fifo
//
// Small synchronous FIFO remembering which requester (and whether it was a
// write) owns each outstanding tag-memory access, so in-order responses can be
// routed back. Supports push and pop in the same cycle, including when full.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset (empties the FIFO)
//   push_i   in   write data_i at the tail
//   pop_i    in   drop the head entry
//   data_i   in   entry to push
//   data_o   out  current head entry (valid when !empty_o)
//   empty_o  out  no entries stored
//   count_o  out  number of entries stored (0..Depth)
// -----------------------------------------------------------------------------
module tag_order_fifo
  import cheri_tag_arbiter_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  tag_order_t               data_i,
  output tag_order_t               data_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_q;
  logic [PtrW-1:0] rd_q;
  logic [PtrW:0]   cnt_q;
  tag_order_t      mem_q [Depth];

  logic full;
  logic do_push;
  logic do_pop;

  assign full    = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full | do_pop);

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PtrW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/cheri_tag_arbiter.sv
// -----------------------------------------------------------------------------
// cheri_tag_arbiter
//
// Round-robin arbiter for capability-tag memory accesses (D-cache, I-cache,
// PTW) onto the single tag-memory port. A request that sees back-pressure is
// locked until the memory accepts it; responses return in order and are routed
// to their originating requester via a small order FIFO.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_i          per-port request valid
//   gnt_o          per-port grant (request accepted this cycle)
//   we_i           per-port write enable
//   addr_i         per-port byte address
//   wtag_i         per-port write tag
//   rvalid_o       per-port response valid (read data or write ack)
//   rtag_o         shared read tag, qualified by rvalid_o (0 for write acks)
//   mem_req_o      tag-memory request
//   mem_gnt_i      tag-memory accept
//   mem_we_o       tag-memory write enable
//   mem_idx_o      granule index (addr >> log2(GranuleBytes))
//   mem_wtag_o     tag-memory write tag
//   mem_rvalid_i   tag-memory response, in request order
//   mem_rtag_i     tag-memory response tag
//   spurious_o     pulse when a response arrives with nothing outstanding
// -----------------------------------------------------------------------------
module cheri_tag_arbiter
  import cheri_tag_arbiter_pkg::*;
#(
  parameter int NrPorts        = 3,
  parameter int AddrWidth      = 64,
  parameter int TagWidth       = 1,
  parameter int GranuleBytes   = CAP_GRANULE_BYTES,
  parameter int MaxOutstanding = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NrPorts-1:0]                     req_i,
  output logic [NrPorts-1:0]                     gnt_o,
  input  logic [NrPorts-1:0]                     we_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NrPorts-1:0][TagWidth-1:0]       wtag_i,
  output logic [NrPorts-1:0]                     rvalid_o,
  output logic [TagWidth-1:0]                    rtag_o,
  output logic                                   mem_req_o,
  input  logic                                   mem_gnt_i,
  output logic                                   mem_we_o,
  output logic [AddrWidth-$clog2(GranuleBytes)-1:0] mem_idx_o,
  output logic [TagWidth-1:0]                    mem_wtag_o,
  input  logic                                   mem_rvalid_i,
  input  logic [TagWidth-1:0]                    mem_rtag_i,
  output logic                                   spurious_o
);

  localparam int PortW     = $clog2(NrPorts);
  localparam int GranShift = $clog2(GranuleBytes);
  localparam int IdxW      = AddrWidth - GranShift;
  localparam int CntW      = $clog2(MaxOutstanding) + 1;

  arb_state_e       state_q, state_d;
  logic [PortW-1:0] lock_q,  lock_d;
  logic [PortW-1:0] rr_q,    rr_d;

  logic [PortW-1:0] sel;
  logic             sel_found;
  logic [PortW-1:0] cur_port;
  logic             any_req;
  logic             fifo_full;
  logic             issue;
  logic             accept;
  logic             pop;

  tag_order_t       push_entry;
  tag_order_t       head;
  logic             fifo_empty;
  logic [CntW-1:0]  fifo_count;

  // Round-robin search: first requesting port at or after rr_q, wrapping.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      int cand;
      cand = (int'(rr_q) + i) % NrPorts;
      if (!sel_found && req_i[cand]) begin
        sel       = PortW'(cand);
        sel_found = 1'b1;
      end
    end
  end

  assign any_req  = |req_i;
  assign cur_port = (state_q == ARB_LOCKED) ? lock_q : sel;

  // A response popping this cycle frees a slot for a request in the same cycle.
  assign fifo_full = (fifo_count == CntW'(MaxOutstanding)) & ~mem_rvalid_i;

  // While locked the held request is re-presented regardless of other inputs;
  // every output is forced low during reset.
  assign issue  = ~rst_i & ((state_q == ARB_LOCKED) | (any_req & ~fifo_full));
  assign accept = issue & mem_gnt_i;
  assign pop    = ~rst_i & mem_rvalid_i & ~fifo_empty;

  assign mem_req_o  = issue;
  assign mem_we_o   = issue & we_i[cur_port];
  assign mem_wtag_o = issue ? wtag_i[cur_port] : '0;
  assign mem_idx_o  = issue ? IdxW'(granule_idx(XLEN'(addr_i[cur_port]), GranShift)) : '0;

  assign gnt_o      = accept ? (NrPorts'(1) << cur_port) : '0;
  assign rvalid_o   = pop ? (NrPorts'(1) << head.port) : '0;
  assign rtag_o     = (pop & ~head.we) ? mem_rtag_i : '0;
  assign spurious_o = ~rst_i & mem_rvalid_i & fifo_empty;

  assign push_entry.port = PORT_IDX_W'(cur_port);
  assign push_entry.we   = we_i[cur_port];

  tag_order_fifo #(
    .Depth   (MaxOutstanding)
  ) u_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
    end
  end

  // Lock onto the winner when the memory stalls it; release on acceptance.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (issue && !mem_gnt_i) begin
          state_d = ARB_LOCKED;
          lock_d  = sel;
        end
      end
      ARB_LOCKED: begin
        if (mem_gnt_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (accept) begin
      rr_d = (cur_port == PortW'(NrPorts - 1)) ? '0 : cur_port + PortW'(1);
    end
  end

endmodule

// File: tb/tb_cheri_tag_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cheri_tag_arbiter
//
// Randomised bench for cheri_tag_arbiter. A behavioural model (pending request
// per port, queue of outstanding owners, tag memory as an associative array)
// predicts every cycle's outputs into a scoreboard queue; a monitor process
// pops and compares each cycle just before the rising edge.
// -----------------------------------------------------------------------------
module tb_cheri_tag_arbiter;

  localparam int NP = 3;
  localparam int AW = 64;
  localparam int TW = 1;
  localparam int GB = 16;
  localparam int MO = 4;
  localparam int IW = AW - 4;

  logic                   clk;
  logic                   rst;
  logic [NP-1:0]          req_i;
  logic [NP-1:0]          gnt_o;
  logic [NP-1:0]          we_i;
  logic [NP-1:0][AW-1:0]  addr_i;
  logic [NP-1:0][TW-1:0]  wtag_i;
  logic [NP-1:0]          rvalid_o;
  logic [TW-1:0]          rtag_o;
  logic                   mem_req_o;
  logic                   mem_gnt_i;
  logic                   mem_we_o;
  logic [IW-1:0]          mem_idx_o;
  logic [TW-1:0]          mem_wtag_o;
  logic                   mem_rvalid_i;
  logic [TW-1:0]          mem_rtag_i;
  logic                   spurious_o;

  cheri_tag_arbiter #(
    .NrPorts        (NP),
    .AddrWidth      (AW),
    .TagWidth       (TW),
    .GranuleBytes   (GB),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wtag_i       (wtag_i),
    .rvalid_o     (rvalid_o),
    .rtag_o       (rtag_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_we_o     (mem_we_o),
    .mem_idx_o    (mem_idx_o),
    .mem_wtag_o   (mem_wtag_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rtag_i   (mem_rtag_i),
    .spurious_o   (spurious_o)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] gnt;
    logic          mreq;
    logic          mwe;
    logic [IW-1:0] midx;
    logic          mwtag;
    logic [NP-1:0] rv;
    logic          rtag;
    logic          spur;
    bit            inrst;
  } exp_t;

  typedef struct {
    int port;
    bit we;
  } ord_t;

  exp_t    expq[$];
  ord_t    ordq[$];
  bit      memq[$];
  bit      tagmem[longint unsigned];

  bit          pend_v[NP];
  bit          pend_we[NP];
  logic [AW-1:0] pend_addr[NP];
  bit          pend_wtag[NP];
  int          rr;
  bit          locked;
  int          lock_port;

  int vectors;
  int miscompares;

  // One comparison: counts it and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Mostly small addresses so reads often hit previously written granules.
  function automatic logic [AW-1:0] randAddr();
    logic [AW-1:0] a;
    a = {32'($urandom), 32'($urandom)};
    if ($urandom_range(0, 3) != 0) a = AW'($urandom_range(0, 255));
    return a;
  endfunction

  task automatic forceReq(input int p, input bit we, input logic [AW-1:0] addr, input bit wtag);
    pend_v[p]    = 1'b1;
    pend_we[p]   = we;
    pend_addr[p] = addr;
    pend_wtag[p] = wtag;
  endtask

  // Drives one cycle of stimulus, predicts its outputs from the model, queues
  // the prediction and advances the model; returns on the next falling edge.
  task automatic applyStimulus(input int req_pct, input int gnt_pct, input int rv_pct,
                               input int spur_pct, input bit do_rst);
    exp_t            e;
    ord_t            o;
    bit              g;
    bit              rv;
    bit              rt;
    bit              pop;
    bit              full;
    int              cand;
    longint unsigned idx;

    for (int p = 0; p < NP; p++) begin
      if (!pend_v[p] && int'($urandom_range(0, 99)) < req_pct)
        forceReq(p, 1'($urandom_range(0, 1)), randAddr(), 1'($urandom_range(0, 1)));
    end
    g  = int'($urandom_range(0, 99)) < gnt_pct;
    rv = 1'b0;
    rt = 1'($urandom_range(0, 1));
    if (!do_rst) begin
      if (memq.size() > 0) begin
        if (int'($urandom_range(0, 99)) < rv_pct) begin
          rv = 1'b1;
          rt = memq[0];
        end
      end else if (int'($urandom_range(0, 99)) < spur_pct) begin
        rv = 1'b1;
      end
    end

    rst = do_rst;
    for (int p = 0; p < NP; p++) begin
      req_i[p]  = pend_v[p];
      we_i[p]   = pend_we[p];
      addr_i[p] = pend_addr[p];
      wtag_i[p] = pend_wtag[p];
    end
    mem_gnt_i    = g;
    mem_rvalid_i = rv;
    mem_rtag_i   = rt;

    e = '{default: 0};
    if (do_rst) begin
      e.inrst = 1'b1;
      rr      = 0;
      locked  = 1'b0;
      ordq.delete();
    end else begin
      pop = rv && ordq.size() > 0;
      if (pop) begin
        e.rv   = NP'(1) << ordq[0].port;
        e.rtag = ordq[0].we ? 1'b0 : rt;
      end
      e.spur = rv && ordq.size() == 0;
      if (rv && memq.size() > 0) void'(memq.pop_front());
      full = ordq.size() == MO && !rv;
      cand = -1;
      if (locked) cand = lock_port;
      else if (!full) begin
        for (int i = 0; i < NP; i++) begin
          if (cand < 0 && pend_v[(rr + i) % NP]) cand = (rr + i) % NP;
        end
      end
      if (pop) void'(ordq.pop_front());
      if (cand >= 0) begin
        e.mreq  = 1'b1;
        e.mwe   = pend_we[cand];
        e.midx  = IW'(pend_addr[cand] / GB);
        e.mwtag = pend_wtag[cand];
        if (g) begin
          e.gnt  = NP'(1) << cand;
          o.port = cand;
          o.we   = pend_we[cand];
          ordq.push_back(o);
          idx = pend_addr[cand] / GB;
          if (pend_we[cand]) begin
            tagmem[idx] = pend_wtag[cand];
            memq.push_back(1'($urandom_range(0, 1)));
          end else begin
            memq.push_back(tagmem.exists(idx) ? tagmem[idx] : 1'b0);
          end
          pend_v[cand] = 1'b0;
          rr           = (cand + 1) % NP;
          locked       = 1'b0;
        end else begin
          locked    = 1'b1;
          lock_port = cand;
        end
      end
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (20) applyStimulus(0, 100, 100, 0, 0);
  endtask

  // Monitor: compares each queued prediction just before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        checkOutput("gnt_o", 64'(gnt_o), 64'(e.gnt));
        checkOutput("mem_req_o", 64'(mem_req_o), 64'(e.mreq));
        checkOutput("rvalid_o", 64'(rvalid_o), 64'(e.rv));
        checkOutput("spurious_o", 64'(spurious_o), 64'(e.spur));
        if (e.mreq || e.inrst) begin
          checkOutput("mem_idx_o", 64'(mem_idx_o), 64'(e.midx));
          checkOutput("mem_we_o", 64'(mem_we_o), 64'(e.mwe));
          checkOutput("mem_wtag_o", 64'(mem_wtag_o), 64'(e.mwtag));
        end
        if (e.rv != '0 || e.inrst) checkOutput("rtag_o", 64'(rtag_o), 64'(e.rtag));
      end
    end
  end

  // Directed scenarios first, then randomised segments with varied traffic rates.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    rr           = 0;
    locked       = 1'b0;
    lock_port    = 0;
    for (int p = 0; p < NP; p++) begin
      pend_v[p] = 1'b0; pend_we[p] = 1'b0; pend_addr[p] = '0; pend_wtag[p] = 1'b0;
    end
    rst          = 1'b1;
    req_i        = '0;
    we_i         = '0;
    addr_i       = '0;
    wtag_i       = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rtag_i   = '0;
    @(negedge clk);

    $display("[TB] reset with requests present");
    repeat (3) applyStimulus(80, 50, 50, 0, 1);

    $display("[TB] round-robin fairness");
    for (int p = 0; p < NP; p++) forceReq(p, 1'b0, randAddr(), 1'b0);
    repeat (9) applyStimulus(100, 100, 100, 0, 0);
    drain();

    $display("[TB] lock under back-pressure");
    forceReq(1, 1'b0, 64'h0000_0000_0000_0120, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);
    forceReq(0, 1'b0, 64'h0000_0000_0000_0040, 1'b0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 100, 100, 0, 0);
    drain();

    $display("[TB] full FIFO and same-cycle pop");
    repeat (8) applyStimulus(100, 100, 0, 0, 0);
    repeat (6) applyStimulus(100, 100, 100, 0, 0);
    drain();

    $display("[TB] index and data routing");
    tagmem[64'h0000_0000_0800_0001] = 1'b1;
    forceReq(2, 1'b0, 64'h0000_0000_8000_001F, 1'b0);
    repeat (3) applyStimulus(0, 100, 100, 0, 0);
    forceReq(1, 1'b1, 64'h0000_0000_8000_0010, 1'b1);
    repeat (3) applyStimulus(0, 100, 100, 0, 0);
    forceReq(0, 1'b1, 64'h0000_0000_8000_0018, 1'b0);
    repeat (3) applyStimulus(0, 100, 100, 0, 0);
    forceReq(2, 1'b0, 64'h0000_0000_8000_0014, 1'b0);
    repeat (3) applyStimulus(0, 100, 100, 0, 0);
    drain();

    $display("[TB] spurious response");
    repeat (3) applyStimulus(0, 100, 0, 100, 0);

    $display("[TB] reset mid-operation");
    drain();
    repeat (2) applyStimulus(100, 100, 0, 0, 0);
    applyStimulus(100, 0, 0, 0, 0);
    repeat (3) applyStimulus(100, 0, 0, 0, 1);
    repeat (4) applyStimulus(0, 0, 100, 0, 0);
    drain();

    $display("[TB] randomised segments");
    for (int s = 0; s < 25; s++) begin
      int rq, gp, rp, sp;
      rq = int'($urandom_range(0, 100));
      gp = int'($urandom_range(0, 100));
      rp = int'($urandom_range(0, 100));
      sp = int'($urandom_range(0, 30));
      repeat (20) applyStimulus(rq, gp, rp, sp, 0);
      if (s == 12) repeat (2) applyStimulus(50, 50, 0, 0, 1);
    end
    drain();

    #6;
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
